// File: rtl/reservation_station.sv
// ----------------------------------------------------------------------------
// reservation_station
//
// Purpose:
//    Buffers up to DEPTH dispatched arithmetic/jump/branch instructions,
//    snoops the ALU and LSB result broadcasts to resolve outstanding source
//    tags, and issues one operand-ready entry per cycle to the ALU.
//
// Ports:
//    clk_in, rst_in           clock, asynchronous active-high reset
//    rdy_in                   global enable (low freezes all state)
//    clear_in                 mispredict flush, drops every entry
//    *_dispatch_in            incoming instruction (qj/qk = 0 means the
//                             matching v* value is already valid)
//    rs_full_out              all entries busy, from registered state only
//    cdb_alu_*, cdb_lsb_*     result broadcasts used for operand wakeup
//    *_alu_out                registered issue port; rdy_alu_out pulses for
//                             one cycle per issued entry
// ----------------------------------------------------------------------------
module reservation_station #(
   parameter int DEPTH      = 16,
   parameter int IDX_WIDTH  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 6,
   parameter int ROB_WIDTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,

   input  logic                  rdy_dispatch_in,
   input  logic [ADDR_WIDTH-1:0] pc_dispatch_in,
   input  logic [OP_WIDTH-1:0]   opcode_dispatch_in,
   input  logic [ROB_WIDTH-1:0]  qj_dispatch_in,
   input  logic [ROB_WIDTH-1:0]  qk_dispatch_in,
   input  logic [DATA_WIDTH-1:0] vj_dispatch_in,
   input  logic [DATA_WIDTH-1:0] vk_dispatch_in,
   input  logic [DATA_WIDTH-1:0] A_dispatch_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_dispatch_in,
   output logic                  rs_full_out,

   input  logic                  cdb_alu_valid_in,
   input  logic [ROB_WIDTH-1:0]  cdb_alu_rob_in,
   input  logic [DATA_WIDTH-1:0] cdb_alu_val_in,
   input  logic                  cdb_lsb_valid_in,
   input  logic [ROB_WIDTH-1:0]  cdb_lsb_rob_in,
   input  logic [DATA_WIDTH-1:0] cdb_lsb_val_in,

   output logic                  rdy_alu_out,
   output logic [OP_WIDTH-1:0]   opcode_alu_out,
   output logic [DATA_WIDTH-1:0] vj_alu_out,
   output logic [DATA_WIDTH-1:0] vk_alu_out,
   output logic [DATA_WIDTH-1:0] A_alu_out,
   output logic [ADDR_WIDTH-1:0] pc_alu_out,
   output logic [ROB_WIDTH-1:0]  rob_id_alu_out
);

   // ------------------------------------------------------------------------
   // Entry state
   // ------------------------------------------------------------------------
   logic [DEPTH-1:0]      busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_d  [DEPTH];
   logic [OP_WIDTH-1:0]   op_q  [DEPTH];
   logic [OP_WIDTH-1:0]   op_d  [DEPTH];
   logic [ROB_WIDTH-1:0]  qj_q  [DEPTH];
   logic [ROB_WIDTH-1:0]  qj_d  [DEPTH];
   logic [ROB_WIDTH-1:0]  qk_q  [DEPTH];
   logic [ROB_WIDTH-1:0]  qk_d  [DEPTH];
   logic [DATA_WIDTH-1:0] vj_q  [DEPTH];
   logic [DATA_WIDTH-1:0] vj_d  [DEPTH];
   logic [DATA_WIDTH-1:0] vk_q  [DEPTH];
   logic [DATA_WIDTH-1:0] vk_d  [DEPTH];
   logic [DATA_WIDTH-1:0] a_q   [DEPTH];
   logic [DATA_WIDTH-1:0] a_d   [DEPTH];
   logic [ROB_WIDTH-1:0]  rob_q [DEPTH];
   logic [ROB_WIDTH-1:0]  rob_d [DEPTH];

   // Issue port registers
   logic                  rdy_alu_q, rdy_alu_d;
   logic [OP_WIDTH-1:0]   op_alu_q, op_alu_d;
   logic [DATA_WIDTH-1:0] vj_alu_q, vj_alu_d;
   logic [DATA_WIDTH-1:0] vk_alu_q, vk_alu_d;
   logic [DATA_WIDTH-1:0] a_alu_q, a_alu_d;
   logic [ADDR_WIDTH-1:0] pc_alu_q, pc_alu_d;
   logic [ROB_WIDTH-1:0]  rob_alu_q, rob_alu_d;

   // ------------------------------------------------------------------------
   // Selection (registered state only)
   // ------------------------------------------------------------------------
   logic                 full;
   logic                 dispatch_en;
   logic [IDX_WIDTH-1:0] alloc_idx;
   logic                 issue_found;
   logic [IDX_WIDTH-1:0] issue_idx;

   assign full        = &busy_q;
   assign dispatch_en = rdy_dispatch_in && !full;
   assign rs_full_out = full;

   // Both priority encoders scan from the top down so the lowest index wins.
   // The allocation pointer deliberately ignores a same-cycle issue: an
   // entry freed this edge only becomes allocatable on the following one.
   always_comb begin
      alloc_idx   = '0;
      issue_found = 1'b0;
      issue_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            alloc_idx = IDX_WIDTH'(i);
         end
         if (busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
            issue_found = 1'b1;
            issue_idx   = IDX_WIDTH'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Dispatch-cycle bypass: a producer broadcasting in the very cycle its
   // consumer is dispatched would otherwise be missed forever. Tag 0 never
   // matches, and the ALU broadcast takes priority over the LSB one.
   // ------------------------------------------------------------------------
   logic [ROB_WIDTH-1:0]  disp_qj, disp_qk;
   logic [DATA_WIDTH-1:0] disp_vj, disp_vk;

   always_comb begin
      disp_qj = qj_dispatch_in;
      disp_vj = vj_dispatch_in;
      disp_qk = qk_dispatch_in;
      disp_vk = vk_dispatch_in;
      if (qj_dispatch_in != '0) begin
         if (cdb_alu_valid_in && (cdb_alu_rob_in == qj_dispatch_in)) begin
            disp_qj = '0;
            disp_vj = cdb_alu_val_in;
         end else if (cdb_lsb_valid_in && (cdb_lsb_rob_in == qj_dispatch_in)) begin
            disp_qj = '0;
            disp_vj = cdb_lsb_val_in;
         end
      end
      if (qk_dispatch_in != '0) begin
         if (cdb_alu_valid_in && (cdb_alu_rob_in == qk_dispatch_in)) begin
            disp_qk = '0;
            disp_vk = cdb_alu_val_in;
         end else if (cdb_lsb_valid_in && (cdb_lsb_rob_in == qk_dispatch_in)) begin
            disp_qk = '0;
            disp_vk = cdb_lsb_val_in;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      busy_d    = busy_q;
      rdy_alu_d = rdy_alu_q;
      op_alu_d  = op_alu_q;
      vj_alu_d  = vj_alu_q;
      vk_alu_d  = vk_alu_q;
      a_alu_d   = a_alu_q;
      pc_alu_d  = pc_alu_q;
      rob_alu_d = rob_alu_q;
      for (int i = 0; i < DEPTH; i++) begin
         pc_d[i]  = pc_q[i];
         op_d[i]  = op_q[i];
         qj_d[i]  = qj_q[i];
         qk_d[i]  = qk_q[i];
         vj_d[i]  = vj_q[i];
         vk_d[i]  = vk_q[i];
         a_d[i]   = a_q[i];
         rob_d[i] = rob_q[i];
      end

      if (rdy_in) begin
         // Wakeup of waiting operands; both operands may resolve together.
         for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && (qj_q[i] != '0)) begin
               if (cdb_alu_valid_in && (cdb_alu_rob_in == qj_q[i])) begin
                  qj_d[i] = '0;
                  vj_d[i] = cdb_alu_val_in;
               end else if (cdb_lsb_valid_in && (cdb_lsb_rob_in == qj_q[i])) begin
                  qj_d[i] = '0;
                  vj_d[i] = cdb_lsb_val_in;
               end
            end
            if (busy_q[i] && (qk_q[i] != '0)) begin
               if (cdb_alu_valid_in && (cdb_alu_rob_in == qk_q[i])) begin
                  qk_d[i] = '0;
                  vk_d[i] = cdb_alu_val_in;
               end else if (cdb_lsb_valid_in && (cdb_lsb_rob_in == qk_q[i])) begin
                  qk_d[i] = '0;
                  vk_d[i] = cdb_lsb_val_in;
               end
            end
         end

         // Issue from registered fields; the chosen entry already has both
         // tags at zero, so wakeup above never touches its operands.
         rdy_alu_d = issue_found;
         if (issue_found) begin
            busy_d[issue_idx] = 1'b0;
            op_alu_d  = op_q[issue_idx];
            vj_alu_d  = vj_q[issue_idx];
            vk_alu_d  = vk_q[issue_idx];
            a_alu_d   = a_q[issue_idx];
            pc_alu_d  = pc_q[issue_idx];
            rob_alu_d = rob_q[issue_idx];
         end

         // Dispatch targets a slot that was free before the edge, so it can
         // never collide with the slot being issued.
         if (dispatch_en) begin
            busy_d[alloc_idx] = 1'b1;
            pc_d[alloc_idx]   = pc_dispatch_in;
            op_d[alloc_idx]   = opcode_dispatch_in;
            qj_d[alloc_idx]   = disp_qj;
            qk_d[alloc_idx]   = disp_qk;
            vj_d[alloc_idx]   = disp_vj;
            vk_d[alloc_idx]   = disp_vk;
            a_d[alloc_idx]    = A_dispatch_in;
            rob_d[alloc_idx]  = rob_id_dispatch_in;
         end

         // Flush wins over everything above. Payloads may be overwritten
         // harmlessly because their busy bits are dropped.
         if (clear_in) begin
            busy_d    = '0;
            rdy_alu_d = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q    <= '0;
         rdy_alu_q <= 1'b0;
         op_alu_q  <= '0;
         vj_alu_q  <= '0;
         vk_alu_q  <= '0;
         a_alu_q   <= '0;
         pc_alu_q  <= '0;
         rob_alu_q <= '0;
      end else begin
         busy_q    <= busy_d;
         rdy_alu_q <= rdy_alu_d;
         op_alu_q  <= op_alu_d;
         vj_alu_q  <= vj_alu_d;
         vk_alu_q  <= vk_alu_d;
         a_alu_q   <= a_alu_d;
         pc_alu_q  <= pc_alu_d;
         rob_alu_q <= rob_alu_d;
      end
   end

   // Entry payloads carry no meaning while their busy bit is low, so they
   // are left out of the reset.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < DEPTH; i++) begin
         pc_q[i]  <= pc_d[i];
         op_q[i]  <= op_d[i];
         qj_q[i]  <= qj_d[i];
         qk_q[i]  <= qk_d[i];
         vj_q[i]  <= vj_d[i];
         vk_q[i]  <= vk_d[i];
         a_q[i]   <= a_d[i];
         rob_q[i] <= rob_d[i];
      end
   end

   assign rdy_alu_out    = rdy_alu_q;
   assign opcode_alu_out = op_alu_q;
   assign vj_alu_out     = vj_alu_q;
   assign vk_alu_out     = vk_alu_q;
   assign A_alu_out      = a_alu_q;
   assign pc_alu_out     = pc_alu_q;
   assign rob_id_alu_out = rob_alu_q;

endmodule

// File: tb/tb_reservation_station.sv
// ----------------------------------------------------------------------------
// tb_reservation_station
//
// Directed bench: a table of per-cycle vectors for single-entry behaviour
// (latency, wakeup, bypass, priority, tag-0 and valid gating), followed by
// hand-written sequences for fill/drain, full-with-issue, flush, freeze and
// reset with live entries. Inputs change 1 time unit after each rising
// edge, outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        d_v;
   logic [31:0] d_pc;
   logic [5:0]  d_op;
   logic [3:0]  d_qj, d_qk, d_rob;
   logic [31:0] d_vj, d_vk, d_a;
   logic        full;
   logic        a_v, l_v;
   logic [3:0]  a_t, l_t;
   logic [31:0] a_val, l_val;
   logic        o_rdy;
   logic [5:0]  o_op;
   logic [31:0] o_vj, o_vk, o_a, o_pc;
   logic [3:0]  o_rob;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reservation_station dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
      .rdy_dispatch_in(d_v), .pc_dispatch_in(d_pc), .opcode_dispatch_in(d_op),
      .qj_dispatch_in(d_qj), .qk_dispatch_in(d_qk),
      .vj_dispatch_in(d_vj), .vk_dispatch_in(d_vk), .A_dispatch_in(d_a),
      .rob_id_dispatch_in(d_rob), .rs_full_out(full),
      .cdb_alu_valid_in(a_v), .cdb_alu_rob_in(a_t), .cdb_alu_val_in(a_val),
      .cdb_lsb_valid_in(l_v), .cdb_lsb_rob_in(l_t), .cdb_lsb_val_in(l_val),
      .rdy_alu_out(o_rdy), .opcode_alu_out(o_op), .vj_alu_out(o_vj),
      .vk_alu_out(o_vk), .A_alu_out(o_a), .pc_alu_out(o_pc),
      .rob_id_alu_out(o_rob)
   );

   // Dispatch while full is a protocol violation by the bench itself.
   always @(posedge clk) begin
      if (!rst && rdy && d_v && full) begin
         failures++;
         $display("FAIL protocol: dispatch while rs_full_out=1 at %0t", $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        disp;
      logic [5:0]  op;
      logic [3:0]  qj, qk, rob;
      logic [31:0] vj, vk, a, pc;
      logic        av, lv;
      logic [3:0]  at, lt;
      logic [31:0] aval, lval;
      logic        e_rdy;
      logic [5:0]  e_op;
      logic [31:0] e_vj, e_vk, e_a, e_pc;
      logic [3:0]  e_rob;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rdy = 1'b1; clear = 1'b0;
      d_v = 1'b0; d_pc = '0; d_op = '0; d_qj = '0; d_qk = '0;
      d_vj = '0; d_vk = '0; d_a = '0; d_rob = '0;
      a_v = 1'b0; a_t = '0; a_val = '0;
      l_v = 1'b0; l_t = '0; l_val = '0;
   endtask

   task automatic drive_disp(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                             input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] a,
                             input logic [31:0] pc, input logic [3:0] rob);
      d_v = 1'b1; d_op = op; d_qj = qj; d_qk = qk;
      d_vj = vj; d_vk = vk; d_a = a; d_pc = pc; d_rob = rob;
   endtask

   task automatic chk_flags(input string name, input logic e_rdy, input logic e_full);
      chk({name, " rdy"}, {31'd0, o_rdy}, {31'd0, e_rdy});
      chk({name, " full"}, {31'd0, full}, {31'd0, e_full});
   endtask

   task automatic chk_issue(input string name, input logic [5:0] op, input logic [31:0] vj,
                            input logic [31:0] vk, input logic [3:0] rob);
      chk({name, " rdy"}, {31'd0, o_rdy}, 32'd1);
      chk({name, " op"}, {26'd0, o_op}, {26'd0, op});
      chk({name, " vj"}, o_vj, vj);
      chk({name, " vk"}, o_vk, vk);
      chk({name, " rob"}, {28'd0, o_rob}, {28'd0, rob});
   endtask

   // Table fill helpers
   task automatic t_disp(input int i, input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] a,
                         input logic [31:0] pc, input logic [3:0] rob);
      tbl[i].disp = 1'b1; tbl[i].op = op; tbl[i].qj = qj; tbl[i].qk = qk;
      tbl[i].vj = vj; tbl[i].vk = vk; tbl[i].a = a; tbl[i].pc = pc; tbl[i].rob = rob;
   endtask

   task automatic t_alu(input int i, input logic v, input logic [3:0] t, input logic [31:0] val);
      tbl[i].av = v; tbl[i].at = t; tbl[i].aval = val;
   endtask

   task automatic t_lsb(input int i, input logic [3:0] t, input logic [31:0] val);
      tbl[i].lv = 1'b1; tbl[i].lt = t; tbl[i].lval = val;
   endtask

   task automatic t_exp(input int i, input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] a, input logic [31:0] pc, input logic [3:0] rob);
      tbl[i].e_rdy = 1'b1; tbl[i].e_op = op; tbl[i].e_vj = vj; tbl[i].e_vk = vk;
      tbl[i].e_a = a; tbl[i].e_pc = pc; tbl[i].e_rob = rob;
   endtask

   initial begin
      // ---------------- vector table ----------------
      for (int i = 0; i < NV; i++) begin
         tbl[i] = '{disp: 1'b0, op: '0, qj: '0, qk: '0, rob: '0, vj: '0, vk: '0, a: '0, pc: '0,
                    av: 1'b0, lv: 1'b0, at: '0, lt: '0, aval: '0, lval: '0,
                    e_rdy: 1'b0, e_op: '0, e_vj: '0, e_vk: '0, e_a: '0, e_pc: '0, e_rob: '0};
      end
      // Ready at dispatch: issues one edge later.
      t_disp(0, 6'h01, 4'd0, 4'd0, 32'd5, 32'd7, 32'h11, 32'h1000, 4'd3);
      t_exp (1, 6'h01, 32'd5, 32'd7, 32'h11, 32'h1000, 4'd3);
      // Waiting on tag 2, ALU broadcast two cycles later.
      t_disp(3, 6'h02, 4'd2, 4'd0, 32'hDEAD, 32'd9, 32'h22, 32'h1004, 4'd4);
      t_alu (5, 1'b1, 4'd2, 32'h100);
      t_exp (6, 6'h02, 32'h100, 32'd9, 32'h22, 32'h1004, 4'd4);
      // Broadcast in the dispatch cycle itself (bypass).
      t_disp(7, 6'h03, 4'd2, 4'd0, 32'hDEAD, 32'h33, 32'h44, 32'h1008, 4'd5);
      t_alu (7, 1'b1, 4'd2, 32'h200);
      t_exp (8, 6'h03, 32'h200, 32'h33, 32'h44, 32'h1008, 4'd5);
      // Bypass on both operands from different buses.
      t_disp(9, 6'h04, 4'd6, 4'd7, 32'hDEAD, 32'hBEEF, 32'h55, 32'h100C, 4'd6);
      t_alu (9, 1'b1, 4'd6, 32'h600);
      t_lsb (9, 4'd7, 32'h700);
      t_exp (10, 6'h04, 32'h600, 32'h700, 32'h55, 32'h100C, 4'd6);
      // Both operands wake together; both buses carry the tag, ALU wins.
      t_disp(11, 6'h05, 4'd8, 4'd8, 32'hDEAD, 32'hBEEF, 32'h66, 32'h1010, 4'd7);
      t_alu (12, 1'b1, 4'd8, 32'hA1);
      t_lsb (12, 4'd8, 32'hB2);
      t_exp (13, 6'h05, 32'hA1, 32'hA1, 32'h66, 32'h1010, 4'd7);
      // Invalid broadcast with a matching tag must not bypass.
      t_disp(14, 6'h06, 4'd9, 4'd0, 32'hDEAD, 32'h606, 32'h88, 32'h1014, 4'd8);
      t_alu (14, 1'b0, 4'd9, 32'h999);
      // Tag-0 broadcast must not disturb a ready operand; younger ready
      // entry (index 1) issues ahead of the older waiting one (index 0).
      t_disp(15, 6'h07, 4'd0, 4'd0, 32'd1, 32'd2, 32'h77, 32'h1018, 4'd9);
      t_alu (15, 1'b1, 4'd0, 32'h123);
      t_exp (16, 6'h07, 32'd1, 32'd2, 32'h77, 32'h1018, 4'd9);
      t_lsb (17, 4'd9, 32'h909);
      t_exp (18, 6'h06, 32'h909, 32'h606, 32'h88, 32'h1014, 4'd8);
      // Rows without an issue expect the previous outputs held, rdy low.
      for (int i = 1; i < NV; i++) begin
         if (!tbl[i].e_rdy) begin
            tbl[i].e_op = tbl[i-1].e_op; tbl[i].e_vj = tbl[i-1].e_vj;
            tbl[i].e_vk = tbl[i-1].e_vk; tbl[i].e_a = tbl[i-1].e_a;
            tbl[i].e_pc = tbl[i-1].e_pc; tbl[i].e_rob = tbl[i-1].e_rob;
         end
      end

      // ---------------- reset ----------------
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_flags("reset", 1'b0, 1'b0);
      chk("reset op", {26'd0, o_op}, 32'd0);
      chk("reset vj", o_vj, 32'd0);
      rst = 1'b0;

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         drive_idle();
         if (tbl[i].disp) drive_disp(tbl[i].op, tbl[i].qj, tbl[i].qk, tbl[i].vj, tbl[i].vk,
                                     tbl[i].a, tbl[i].pc, tbl[i].rob);
         a_v = tbl[i].av; a_t = tbl[i].at; a_val = tbl[i].aval;
         l_v = tbl[i].lv; l_t = tbl[i].lt; l_val = tbl[i].lval;
         tick();
         chk($sformatf("tbl%0d rdy", i), {31'd0, o_rdy}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("tbl%0d full", i), {31'd0, full}, 32'd0);
         chk($sformatf("tbl%0d op", i), {26'd0, o_op}, {26'd0, tbl[i].e_op});
         chk($sformatf("tbl%0d vj", i), o_vj, tbl[i].e_vj);
         chk($sformatf("tbl%0d vk", i), o_vk, tbl[i].e_vk);
         chk($sformatf("tbl%0d A", i), o_a, tbl[i].e_a);
         chk($sformatf("tbl%0d pc", i), o_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d rob", i), {28'd0, o_rob}, {28'd0, tbl[i].e_rob});
      end

      // ---------------- fill 16, wake all, drain in order ----------------
      for (int i = 0; i < 16; i++) begin
         drive_idle();
         drive_disp(6'(i), 4'd4, 4'd0, 32'hDEAD, 32'h10 + 32'(i), 32'(i),
                    32'h2000 + 32'(4 * i), 4'((i % 15) + 1));
         tick();
         chk_flags($sformatf("fill%0d", i), 1'b0, i == 15);
      end
      drive_idle();
      l_v = 1'b1; l_t = 4'd4; l_val = 32'd1;
      tick();
      chk_flags("wake all", 1'b0, 1'b1);
      drive_idle();
      for (int j = 0; j < 16; j++) begin
         tick();
         chk_issue($sformatf("drain%0d", j), 6'(j), 32'd1, 32'h10 + 32'(j), 4'((j % 15) + 1));
         chk($sformatf("drain%0d full", j), {31'd0, full}, 32'd0);
         chk($sformatf("drain%0d pc", j), o_pc, 32'h2000 + 32'(4 * j));
      end
      tick();
      chk_flags("drained", 1'b0, 1'b0);

      // ---------------- full with an issue, then refill freed slot ----------------
      for (int i = 0; i < 16; i++) begin
         drive_idle();
         drive_disp(6'h20 + 6'(i), (i < 15) ? 4'd5 : 4'd0, 4'd0, 32'h5000 + 32'(i), 32'(i),
                    32'd0, 32'h3000, 4'd1);
         tick();
         chk_flags($sformatf("fillB%0d", i), 1'b0, i == 15);
      end
      drive_idle();
      tick();
      chk_issue("full issue", 6'h2F, 32'h500F, 32'd15, 4'd1);
      chk("full issue full", {31'd0, full}, 32'd0);
      drive_disp(6'h3E, 4'd0, 4'd0, 32'hE1, 32'hE2, 32'd0, 32'h3004, 4'hE);
      tick();
      chk_flags("refill", 1'b0, 1'b1);
      drive_idle();
      tick();
      chk_issue("refill issue", 6'h3E, 32'hE1, 32'hE2, 4'hE);
      chk("refill issue full", {31'd0, full}, 32'd0);

      // ---------------- flush with concurrent dispatch and ready entries ----------------
      a_v = 1'b1; a_t = 4'd5; a_val = 32'h55;
      tick();
      chk_flags("pre-flush wake", 1'b0, 1'b0);
      drive_idle();
      clear = 1'b1;
      drive_disp(6'h3D, 4'd0, 4'd0, 32'hD1, 32'hD2, 32'd0, 32'h3008, 4'hD);
      tick();
      chk_flags("flush", 1'b0, 1'b0);
      drive_idle();
      tick();
      chk_flags("flush+1", 1'b0, 1'b0);
      tick();
      chk_flags("flush+2", 1'b0, 1'b0);

      // ---------------- freeze mid-stream ----------------
      drive_disp(6'h01, 4'd0, 4'd0, 32'h41A, 32'h41B, 32'd0, 32'h4000, 4'd1);
      tick();
      chk_flags("P disp", 1'b0, 1'b0);
      drive_disp(6'h02, 4'd0, 4'd0, 32'h42A, 32'h42B, 32'd0, 32'h4004, 4'd2);
      tick();
      chk_issue("P issue", 6'h01, 32'h41A, 32'h41B, 4'd1);
      drive_idle();
      rdy = 1'b0;
      clear = 1'b1;
      drive_disp(6'h03, 4'd0, 4'd0, 32'h43A, 32'h43B, 32'd0, 32'h4008, 4'd3);
      a_v = 1'b1; a_t = 4'd1; a_val = 32'h999;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_issue($sformatf("freeze%0d", k), 6'h01, 32'h41A, 32'h41B, 4'd1);
         chk($sformatf("freeze%0d full", k), {31'd0, full}, 32'd0);
      end
      drive_idle();
      tick();
      chk_issue("Q issue", 6'h02, 32'h42A, 32'h42B, 4'd2);
      tick();
      chk_flags("after Q", 1'b0, 1'b0);

      // ---------------- reset with busy entries ----------------
      drive_disp(6'h10, 4'd7, 4'd0, 32'hBAD0, 32'hBAD1, 32'd0, 32'h5000, 4'd1);
      tick();
      drive_disp(6'h11, 4'd7, 4'd0, 32'hBAD2, 32'hBAD3, 32'd0, 32'h5004, 4'd2);
      tick();
      drive_idle();
      rst = 1'b1;
      #2;
      chk_flags("async reset", 1'b0, 1'b0);
      chk("async reset op", {26'd0, o_op}, 32'd0);
      chk("async reset pc", o_pc, 32'd0);
      chk("async reset rob", {28'd0, o_rob}, 32'd0);
      rst = 1'b0;
      drive_disp(6'h30, 4'd7, 4'd0, 32'd0, 32'h601, 32'd0, 32'h6000, 4'd3);
      tick();
      drive_disp(6'h31, 4'd7, 4'd0, 32'd0, 32'h602, 32'd0, 32'h6004, 4'd4);
      tick();
      drive_idle();
      a_v = 1'b1; a_t = 4'd7; a_val = 32'h77;
      tick();
      chk_flags("post-reset wake", 1'b0, 1'b0);
      drive_idle();
      tick();
      chk_issue("post-reset first", 6'h30, 32'h77, 32'h601, 4'd3);
      tick();
      chk_issue("post-reset second", 6'h31, 32'h77, 32'h602, 4'd4);
      tick();
      chk_flags("post-reset empty", 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
